// File: rtl/fifo_stream_reader.sv
// Prefetching read adapter: turns a FIFO read port with latency 0, 1 or 2 into a valid/ready stream.
// Define FIFO_STREAM_READER_FLUSH_EN to add flush_i, which drops buffered and in-flight words.

module fifo_stream_reader_chk #(
    parameter int OCC_W     = 2,
    parameter int BUF_DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             capture_i,
    input  logic [OCC_W-1:0] occupancy_i
);

    // The read credit must never let a returning word land in a full buffer
    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(capture_i && (occupancy_i == OCC_W'(BUF_DEPTH)))
    );

endmodule

module fifo_stream_reader #(
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                fifo_empty_i,
    output logic                                fifo_rd_en_o,
    input  logic [WIDTH-1:0]                    fifo_rd_data_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [WIDTH-1:0]                    out_data_o,
    output logic [$clog2(READ_LATENCY+3)-1:0]   occupancy_o
`ifdef FIFO_STREAM_READER_FLUSH_EN
    ,
    input  logic                                flush_i
`endif
);

    localparam int BUF_DEPTH = READ_LATENCY + 2;
    localparam int OCC_W     = $clog2(READ_LATENCY + 3);
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int TRK_W     = (READ_LATENCY == 0) ? 1 : READ_LATENCY;
    localparam int SUM_W     = OCC_W + 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    logic             flush_s;
    logic [WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             valid_q;
    logic [TRK_W-1:0] trk_q, trk_d;
    logic [SUM_W-1:0] inflight_s;
    logic             credit_ok_s;
    logic             rd_en_s;
    logic             capture_s;
    logic             pop_s;

`ifdef FIFO_STREAM_READER_FLUSH_EN
    assign flush_s = flush_i;
`else
    assign flush_s = 1'b0;
`endif

    // Tracker stage i set means a word requested i+1 cycles ago is still on its way
    generate
        if (READ_LATENCY == 0) begin : g_trk_none
            assign trk_d     = 1'b0;
            assign capture_s = rd_en_s;
        end else if (READ_LATENCY == 1) begin : g_trk_one
            assign trk_d     = flush_s ? 1'b0 : rd_en_s;
            assign capture_s = trk_q[0];
        end else begin : g_trk_multi
            assign trk_d     = flush_s ? '0 : {trk_q[TRK_W-2:0], rd_en_s};
            assign capture_s = trk_q[TRK_W-1];
        end
    endgenerate

    // Count words already requested but not yet returned
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < TRK_W; i++) begin
            inflight_s = inflight_s + SUM_W'(trk_q[i]);
        end
    end

    // Reserve a slot for every in-flight word so a return can never overflow
    assign credit_ok_s = (({1'b0, occ_q} + inflight_s) < SUM_W'(BUF_DEPTH));
    assign rd_en_s     = !rst_i && !fifo_empty_i && !flush_s && credit_ok_s;
    assign pop_s       = valid_q && out_ready_i;

    // Pointer and occupancy next state; flush returns everything to empty
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush_s) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (capture_s) begin
                tail_d = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            case ({capture_s, pop_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state; valid is precomputed from next occupancy so it leaves a flop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
            trk_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= (occ_d != '0);
            trk_q   <= trk_d;
        end
    end

    // Prefetch storage; a word returning during flush is discarded
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (capture_s && !flush_s) begin
            buf_q[tail_q] <= fifo_rd_data_i;
        end
    end

    assign fifo_rd_en_o = rd_en_s;
    assign out_valid_o  = valid_q;
    assign out_data_o   = buf_q[head_q];
    assign occupancy_o  = occ_q;

    fifo_stream_reader_chk #(
        .OCC_W     (OCC_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .capture_i   (capture_s),
        .occupancy_i (occ_q)
    );

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the team's synchronous FIFO. It drives the FIFO read port, with its read_latency of 0, 1 or 2 cycles, and presents the words as a valid/ready stream. A small prefetch buffer absorbs the read latency, so the stream sustains one word per cycle with no combinational path from out_ready to the FIFO. It sits between any FIFO instance and a downstream stream consumer.

## Interface
- width, 8, data word width in bits; must match the FIFO.
- read_latency, 1, FIFO read latency in cycles; legal values 0, 1, 2; must match the FIFO.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  width  FIFO read data, valid read_latency cycles after fifo_rd_en.
- out_valid  out  1  stream word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  width  stream word.
- occupancy  out  $clog2(read_latency+3)  number of words held in the prefetch buffer.
- flush  in  1  discard buffered and in-flight words; present only with the macro (see Configuration).

## Operation
- BUF_DEPTH = read_latency+2 entries. Circular buffer with head/tail pointers and an occupancy counter.
- In-flight tracker: a read_latency-stage valid shift register. Bit 0 is loaded with fifo_rd_en; the last stage marks the cycle in which fifo_rd_data holds a returned word.
- fifo_rd_en = !rst && !fifo_empty && (occupancy + inflight_count) < BUF_DEPTH && !flush.
  - inflight_count is the number of set tracker bits.
  - fifo_rd_en never depends on out_ready, and is never asserted while fifo_empty=1.
- Capture:
  - read_latency=0: fifo_rd_data is written at the tail in the same cycle that fifo_rd_en=1.
  - Otherwise: fifo_rd_data is written when the last tracker stage is 1.
- Pop: when out_valid && out_ready, the head advances.
- occupancy update:
  - next = occupancy + capture - pop.
  - A simultaneous capture and pop leaves it unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - The credit rule guarantees no overflow. Capture into a full buffer is unreachable and must be asserted against in simulation.
- out_valid = (occupancy != 0). out_data = buffer[head], registered storage, with no path from fifo_rd_data.
- Stream rule: once out_valid=1, out_valid and out_data stay stable until accepted.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0, fifo_rd_en=0, tracker cleared, pointers 0.
- First-word latency: fifo_empty falls at cycle t, so fifo_rd_en=1 at t, capture at the edge ending t+read_latency, and out_valid=1 at t+read_latency+1.
- Throughput: with out_ready held high and the FIFO non-empty, fifo_rd_en=1 every cycle and the stream transfers one word per cycle indefinitely.
- Backpressure: with out_ready low, reads stop once occupancy + inflight_count = BUF_DEPTH. No word is lost or duplicated.
- Reset mid-operation: all state clears immediately (asynchronous). In-flight FIFO data is dropped; the FIFO is reset by the same rst.

## Configuration
- Macro: FIFO_STREAM_READER_FLUSH_EN.
- Defined:
  - The flush port exists.
  - A cycle with flush=1 forces fifo_rd_en=0 and clears occupancy, the pointers and the tracker at the next edge.
  - out_valid=0 the cycle after flush.
  - A pop in the flush cycle is still a completed transfer.
  - The FIFO contents are untouched.
- Undefined: there is no flush port, and the logic is tied as if flush=0.

## Test plan
- Reset then idle, fifo_empty=1 -> fifo_rd_en=0, out_valid=0, occupancy=0 throughout.
- read_latency=2, push 0x01..0x10 into the FIFO, out_ready=1 -> out_valid first rises 3 cycles after fifo_empty falls, then 16 consecutive words 0x01..0x10 with no gaps.
- read_latency=1, 8 words, out_ready low for 10 cycles then high -> occupancy saturates at 3, fifo_rd_en deasserts, order 0x01..0x08 preserved with no loss or duplication.
- read_latency=0, out_ready toggling randomly over 200 words -> output sequence equals input sequence; out_data stable while out_valid && !out_ready.
- rst pulsed mid-stream with 2 words buffered -> outputs return to their reset values immediately; after refill, the stream resumes with new data only.
- FIFO_STREAM_READER_FLUSH_EN, read_latency=2, flush for 1 cycle with 2 buffered and 2 in flight -> out_valid=0 the next cycle, the 2 in-flight words are discarded, and the next word out is the 5th word from the FIFO.
